alu_iter: RTL

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mul_iter.sv | 82 ++++++++
 rtl/alu_iter.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
// Provides the 3-bit operation codes (also consumed by the ALU control
// decoder) and the controller state type.
package alu_pkg;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] MUL = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one iteration per step, low WIDTH product
// bits kept.
// Configuration: ALU_ITER_EARLY_EXIT_EN ends the multiply as soon as the
// remaining multiplier is zero; otherwise exactly WIDTH iterations run.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset (clears all datapath state)
//   load_i     load operands, clear accumulator and counter
//   step_i     perform one shift-add iteration this edge
//   mcand_i    multiplicand to load
//   mplier_i   multiplier to load
//   done_o     this step is the final iteration
//   product_o  accumulator value after the current iteration
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;
  logic             last_iter;

  always_comb begin
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef ALU_ITER_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: further iterations add nothing.
    done_o = step_i && (last_iter || ((mplier_q >> 1) == '0));
`else
    done_o = step_i && last_iter;
`endif
    product_o = acc_next;
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_next;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: add/sub/and/or in one cycle, multiply via an iterative
// shift-add sub-module. Unused codes return zero.
// Configuration: ALU_ITER_EARLY_EXIT_EN (see alu_mul_iter) shortens the
// multiply latency; results are identical in both builds.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset, priority over start_i
//   start_i    operation request, accepted when ready_o=1
//   ALUCtrl_i  opcode: 000 add, 001 sub, 010 and, 011 or, 100 mul
//   data1_i    first operand / multiplicand
//   data2_i    second operand / multiplier
//   ready_o    idle and able to accept start_i
//   valid_o    one-cycle pulse marking a new result
//   data_o     registered result, held until the next result
//   zero_o     registered data_o==0 flag
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic             mul_load;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  always_comb begin
    case (ALUCtrl_i)
      ADD:     alu_res = data1_i + data2_i;
      SUB:     alu_res = data1_i - data2_i;
      AND:     alu_res = data1_i & data2_i;
      OR:      alu_res = data1_i | data2_i;
      default: alu_res = '0;
    endcase
  end

  assign accept   = start_i && (state_q == ST_IDLE);
  assign mul_load = accept && (ALUCtrl_i == MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (mul_load),
    .step_i    (state_q == ST_MUL),
    .mcand_i   (data1_i),
    .mplier_i  (data2_i),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mul_load) begin
          state_d = ST_MUL;
        end else if (accept) begin
          data_d  = alu_res;
          zero_d  = (alu_res == '0);
          valid_d = 1'b1;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          data_d  = mul_prod;
          zero_d  = (mul_prod == '0);
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule
